// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output path.
// Samples travel as 32-bit {imag, real} words, matching the FFT input packing.
package fft_pkg;

    localparam int N_POINTS  = 64;
    localparam int FFT_OUT_W = 48;
    localparam int RE_LSB    = 0;
    localparam int IM_LSB    = 24;
    localparam int IN_W      = 19;
    localparam int OUT_W     = 16;

    typedef struct packed {
        logic signed [OUT_W-1:0] im;
        logic signed [OUT_W-1:0] re;
    } sample_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/fft_sat_scale.sv
// Arithmetic right shift of a signed FFT field followed by saturation to OUT_W bits.
// The field is widened first so the saturation compare can never overflow.
module fft_sat_scale #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] y_o,
    output logic             sat_o
);

    localparam int EW = IN_W + OUT_W;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EW-1:0] x_ext;
    logic signed [EW-1:0] y_ext;

    assign x_ext = {{OUT_W{x_i[IN_W-1]}}, x_i};
    assign y_ext = x_ext >>> SHIFT;

    always_comb begin
        y_o   = y_ext[OUT_W-1:0];
        sat_o = 1'b0;
        if (y_ext > SAT_MAX) begin
            y_o   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_o = 1'b1;
        end else if (y_ext < SAT_MIN) begin
            y_o   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fft_out_collector.sv
// Collects one FFT output frame, scaled and saturated at write time, then replays it
// downstream as {imag, real} words. Input is stalled for the whole drain.
module fft_out_collector #(
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int IN_W     = fft_pkg::IN_W,
    parameter int OUT_W    = fft_pkg::OUT_W,
    parameter int SHIFT    = 0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [fft_pkg::FFT_OUT_W-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [2*OUT_W-1:0]            m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          sat_event,
    output logic                          err_tlast_unexpected,
    output logic                          err_tlast_missing,
    output logic [7:0]                    frame_cnt
);
    import fft_pkg::*;

    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             sat_q, sat_d;
    logic             unexp_q, unexp_d;
    logic             miss_q, miss_d;
    logic [2*OUT_W-1:0] buf_q [N_POINTS];

    logic [OUT_W-1:0] re_s, im_s;
    logic             re_sat, im_sat;
    logic             in_fire, out_fire;
    logic             unused_tdata;

    fft_sat_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scale_re (
        .x_i  (s_axis_tdata[RE_LSB +: IN_W]),
        .y_o  (re_s),
        .sat_o(re_sat)
    );

    fft_sat_scale #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scale_im (
        .x_i  (s_axis_tdata[IM_LSB +: IN_W]),
        .y_o  (im_s),
        .sat_o(im_sat)
    );

    // Padding bits between and above the two fields carry no information.
    assign unused_tdata = ^{s_axis_tdata[FFT_OUT_W-1:IM_LSB+IN_W],
                            s_axis_tdata[IM_LSB-1:RE_LSB+IN_W]};

    assign in_fire  = s_axis_tvalid & s_axis_tready;
    assign out_fire = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && wr_addr_q == LAST) state_d = DRAIN;
            DRAIN:   if (out_fire && rd_addr_q == LAST) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_axis_tready = (state_q == FILL) && !Rst;
        m_axis_tvalid = (state_q == DRAIN);
        m_axis_tlast  = (state_q == DRAIN) && (rd_addr_q == LAST);
        m_axis_tdata  = (state_q == DRAIN) ? buf_q[rd_addr_q] : '0;
    end

    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        frame_cnt_d = frame_cnt_q;
        sat_d       = 1'b0;
        unexp_d     = 1'b0;
        miss_d      = 1'b0;
        if (in_fire) begin
            sat_d = re_sat | im_sat;
            if (wr_addr_q == LAST) begin
                miss_d    = !s_axis_tlast;
                wr_addr_d = '0;
            end else if (s_axis_tlast) begin
                // Short frame: drop what was collected and wait for a fresh one.
                unexp_d   = 1'b1;
                wr_addr_d = '0;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
        if (out_fire) begin
            if (rd_addr_q == LAST) begin
                rd_addr_d   = '0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            frame_cnt_q <= '0;
            sat_q       <= 1'b0;
            unexp_q     <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            frame_cnt_q <= frame_cnt_d;
            sat_q       <= sat_d;
            unexp_q     <= unexp_d;
            miss_q      <= miss_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (in_fire) begin
            buf_q[wr_addr_q] <= {im_s, re_s};
        end
    end

    assign sat_event            = sat_q;
    assign err_tlast_unexpected = unexp_q;
    assign err_tlast_missing    = miss_q;
    assign frame_cnt            = frame_cnt_q;

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed bench for fft_out_collector: framing errors, saturation, backpressure, reset.
// A second instance with SHIFT=2 covers the shifted scaling path.
module tb_fft_out_collector;
    import fft_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [47:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic        sat_event, err_tlast_unexpected, err_tlast_missing;
    logic [7:0]  frame_cnt;

    logic [47:0] s2_s_tdata;
    logic        s2_s_tvalid, s2_s_tready, s2_s_tlast;
    logic [31:0] s2_m_tdata;
    logic        s2_m_tvalid, s2_m_tready, s2_m_tlast;
    logic        s2_sat, s2_unexp, s2_miss;
    logic [7:0]  s2_frame_cnt;

    always #5 Clk = ~Clk;

    fft_out_collector u_dut (
        .Clk(Clk), .Rst(Rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .sat_event(sat_event), .err_tlast_unexpected(err_tlast_unexpected),
        .err_tlast_missing(err_tlast_missing), .frame_cnt(frame_cnt)
    );

    fft_out_collector #(.SHIFT(2)) u_dut_s2 (
        .Clk(Clk), .Rst(Rst),
        .s_axis_tdata(s2_s_tdata), .s_axis_tvalid(s2_s_tvalid),
        .s_axis_tready(s2_s_tready), .s_axis_tlast(s2_s_tlast),
        .m_axis_tdata(s2_m_tdata), .m_axis_tvalid(s2_m_tvalid),
        .m_axis_tready(s2_m_tready), .m_axis_tlast(s2_m_tlast),
        .sat_event(s2_sat), .err_tlast_unexpected(s2_unexp),
        .err_tlast_missing(s2_miss), .frame_cnt(s2_frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    logic [31:0] out_data [1024];
    logic        out_last [1024];
    int          out_n = 0;
    int          sat_cnt = 0, unexp_cnt = 0, miss_cnt = 0;
    int          stab_err = 0, s_busy = 0, s2_sat_cnt = 0, s2_err_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge Clk) begin
        if (sat_event)            sat_cnt   <= sat_cnt + 1;
        if (err_tlast_unexpected) unexp_cnt <= unexp_cnt + 1;
        if (err_tlast_missing)    miss_cnt  <= miss_cnt + 1;
        if (s2_sat)               s2_sat_cnt <= s2_sat_cnt + 1;
        if (s2_unexp || s2_miss)  s2_err_cnt <= s2_err_cnt + 1;
        if (m_axis_tvalid && s_axis_tready) s_busy <= s_busy + 1;
        if (m_axis_tvalid && prev_stall &&
            (m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stab_err <= stab_err + 1;
        if (m_axis_tvalid && m_axis_tready && out_n < 1024) begin
            out_data[out_n] <= m_axis_tdata;
            out_last[out_n] <= m_axis_tlast;
            out_n           <= out_n + 1;
        end
        prev_stall <= m_axis_tvalid && !m_axis_tready;
        prev_data  <= m_axis_tdata;
        prev_last  <= m_axis_tlast;
    end

    int          in_re [64];
    int          in_im [64];
    logic [31:0] exp_d [64];

    function automatic logic [47:0] pack(input int re, input int im);
        logic [47:0] d;
        d        = '0;
        d[47:43] = 5'h15;
        d[42:24] = im[18:0];
        d[23:19] = 5'h0A;
        d[18:0]  = re[18:0];
        return d;
    endfunction

    task automatic fill_exp();
        for (int k = 0; k < 64; k++) exp_d[k] = {in_im[k][15:0], in_re[k][15:0]};
    endtask

    task automatic set_ramp(input int re_off, input int im_off, input int re_mul, input int im_mul);
        for (int k = 0; k < 64; k++) begin
            in_re[k] = re_off + re_mul * k;
            in_im[k] = im_off + im_mul * k;
        end
        fill_exp();
    endtask

    task automatic send_frame(input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            @(posedge Clk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pack(in_re[k], in_im[k]);
            s_axis_tlast  = (k == last_at);
        end
        @(posedge Clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input int n, input bit bp, input int start, input string tag);
        int c = 0;
        while ((out_n - start) < n && c < 600) begin
            @(posedge Clk); #1;
            m_axis_tready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            c++;
            @(negedge Clk); #1;
        end
        check({tag, "_beats"}, out_n - start, n);
    endtask

    task automatic verify(input int start, input string tag);
        for (int k = 0; k < 64; k++) begin
            check($sformatf("%s_d%0d", tag, k), out_data[start + k], exp_d[k]);
            check($sformatf("%s_l%0d", tag, k), out_last[start + k], (k == 63));
        end
    endtask

    task automatic finish_frame(input string tag, input int fc);
        @(posedge Clk); #1;
        check({tag, "_tvalid_drop"}, m_axis_tvalid, 1'b0);
        check({tag, "_sready_back"}, s_axis_tready, 1'b1);
        check({tag, "_frame_cnt"}, frame_cnt, fc);
    endtask

    int start, b_sat, b_unexp, b_miss, b_stab, b_busy;

    task automatic snap();
        start   = out_n;
        b_sat   = sat_cnt;
        b_unexp = unexp_cnt;
        b_miss  = miss_cnt;
        b_stab  = stab_err;
        b_busy  = s_busy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        s2_s_tdata = '0; s2_s_tvalid = 1'b0; s2_s_tlast = 1'b0; s2_m_tready = 1'b0;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_sready", s_axis_tready, 1'b0);
        check("rst_mvalid", m_axis_tvalid, 1'b0);
        check("rst_mdata", m_axis_tdata, 32'h0);
        check("rst_mlast", m_axis_tlast, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        check("rst_pulses", {sat_event, err_tlast_unexpected, err_tlast_missing}, 3'b000);
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_sready", s_axis_tready, 1'b1);

        // Ramp frame
        set_ramp(0, 0, 1, -1);
        snap();
        send_frame(64, 63);
        check("ramp_latency_valid", m_axis_tvalid, 1'b1);
        check("ramp_sready_low", s_axis_tready, 1'b0);
        drain(64, 1'b0, start, "ramp");
        verify(start, "ramp");
        finish_frame("ramp", 1);
        check("ramp_no_events", sat_cnt - b_sat + unexp_cnt - b_unexp + miss_cnt - b_miss, 0);

        // Saturation boundaries with SHIFT=0
        set_ramp(0, 0, 0, 0);
        in_re[0] = 40000;   in_im[0] = -40000;
        in_re[1] = 32767;   in_im[1] = -32768;
        in_re[2] = 32768;   in_im[2] = -32769;
        in_re[3] = -262144; in_im[3] = 262143;
        fill_exp();
        exp_d[0] = 32'h8000_7FFF;
        exp_d[1] = 32'h8000_7FFF;
        exp_d[2] = 32'h8000_7FFF;
        exp_d[3] = 32'h7FFF_8000;
        snap();
        send_frame(64, 63);
        drain(64, 1'b0, start, "sat");
        verify(start, "sat");
        finish_frame("sat", 2);
        check("sat_pulses", sat_cnt - b_sat, 3);

        // Early tlast, then a clean frame
        set_ramp(0, 0, 1, -1);
        snap();
        send_frame(11, 10);
        repeat (3) @(posedge Clk);
        #1;
        check("early_unexp", unexp_cnt - b_unexp, 1);
        check("early_no_output", out_n - start, 0);
        check("early_mvalid", m_axis_tvalid, 1'b0);
        check("early_sready", s_axis_tready, 1'b1);
        set_ramp(7, 300, 2, -3);
        snap();
        send_frame(64, 63);
        drain(64, 1'b0, start, "after_early");
        verify(start, "after_early");
        finish_frame("after_early", 3);
        check("after_early_errs", unexp_cnt - b_unexp + miss_cnt - b_miss, 0);

        // Missing tlast
        set_ramp(0, 1000, 3, 1);
        snap();
        send_frame(64, -1);
        drain(64, 1'b0, start, "miss");
        verify(start, "miss");
        finish_frame("miss", 4);
        check("miss_pulse", miss_cnt - b_miss, 1);
        check("miss_no_unexp", unexp_cnt - b_unexp, 0);

        // Backpressure 1,0,0,1
        set_ramp(0, 0, -7, 11);
        snap();
        send_frame(64, 63);
        drain(64, 1'b1, start, "bp");
        verify(start, "bp");
        m_axis_tready = 1'b1;
        finish_frame("bp", 5);
        check("bp_stable", stab_err - b_stab, 0);
        check("bp_sready_low", s_busy - b_busy, 0);

        // Reset in the middle of a drain
        set_ramp(0, 0, 1, 1);
        snap();
        send_frame(64, 63);
        drain(20, 1'b0, start, "mid");
        @(posedge Clk); #1;
        Rst = 1'b1;
        m_axis_tready = 1'b0;
        @(posedge Clk); #1;
        check("mid_rst_mvalid", m_axis_tvalid, 1'b0);
        check("mid_rst_frame_cnt", frame_cnt, 8'd0);
        check("mid_rst_mdata", m_axis_tdata, 32'h0);
        Rst = 1'b0;
        m_axis_tready = 1'b1;
        set_ramp(500, -500, 1, 1);
        snap();
        send_frame(64, 63);
        drain(64, 1'b0, start, "fresh");
        verify(start, "fresh");
        finish_frame("fresh", 1);

        // SHIFT=2 instance: -5 -> -2 with no saturation; -262144 -> -65536 saturates
        begin
            int base2;
            base2 = s2_sat_cnt;
            for (int k = 0; k < 64; k++) begin
                @(posedge Clk); #1;
                s2_s_tvalid = 1'b1;
                s2_s_tdata  = (k == 0) ? pack(-5, 7) : (k == 1) ? pack(-262144, 131071) : pack(0, 0);
                s2_s_tlast  = (k == 63);
            end
            @(posedge Clk); #1;
            s2_s_tvalid = 1'b0;
            s2_s_tlast  = 1'b0;
            check("s2_valid", s2_m_tvalid, 1'b1);
            check("s2_beat0", s2_m_tdata, 32'h0001_FFFE);
            @(posedge Clk); #1;
            check("s2_beat0_hold", s2_m_tdata, 32'h0001_FFFE);
            s2_m_tready = 1'b1;
            @(posedge Clk); #1;
            check("s2_beat1", s2_m_tdata, 32'h7FFF_8000);
            repeat (63) @(posedge Clk);
            #1;
            check("s2_done", s2_m_tvalid, 1'b0);
            check("s2_frame_cnt", s2_frame_cnt, 8'd1);
            check("s2_sat_pulses", s2_sat_cnt - base2, 1);
            check("s2_no_errs", s2_err_cnt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
